// File: rtl/mac_pkg.sv
// Shared defaults and FSM state encoding for the MAC result drain.
package mac_pkg;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/mac_drain_fifo.sv
// Small circular result buffer; push and pop may coincide at any occupancy, including full.
module mac_drain_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 17,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    // At full the popped slot is the one being written, so a concurrent push is safe.
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= next_ptr(r_wr);
            if (w_pop)  r_rd <= next_ptr(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    assign o_valid = (r_count != '0);
    assign o_dout  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/mac_result_drain.sv
// Sequences one dot-product job on the PE, scales/saturates its sum and buffers results.
// Define MAC_DRAIN_ROUND_EN for round-half-up scaling; otherwise scaling floors.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              len,
    output logic                    start_ready,
    output logic                    op_en,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    pe_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_sat
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
`ifdef MAC_DRAIN_ROUND_EN
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(longint'(1) << (SHIFT - 1));
`endif

    state_t           r_state;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;
    logic [CNT_W-1:0] w_count;
    logic             w_accept;
    logic             w_push;
    logic [OUT_W:0]   w_din;
    logic [OUT_W:0]   w_dout;

    // One guard bit keeps the rounding add free of overflow.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] w_ext;
        w_ext = {acc[ACC_W-1], acc};
`ifdef MAC_DRAIN_ROUND_EN
        w_ext = w_ext + RND_HALF;
`endif
        return w_ext >>> SHIFT;
    endfunction

    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
        if (r < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    // The FIFO slot is reserved at acceptance, so no push is ever refused.
    assign start_ready = (r_state == IDLE) && (w_count < CNT_W'(DEPTH));
    assign w_accept    = start && start_ready;
    assign op_en       = (r_state == ACCUM);
    assign pe_clr      = rst || (r_state == IDLE);
    assign w_push      = (w_accept && (len == 8'd0)) || (r_state == WAIT);
    assign w_din       = (r_state == WAIT) ? saturate(round_shift(acc_in)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (len != 8'd0)) begin
                        r_len   <= len;
                        r_cnt   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 8'd1;
                        if ((r_cnt + 8'd1) == r_len) r_state <= WAIT;
                    end
                end
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    mac_drain_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W + 1),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    assign out_sat  = w_dout[OUT_W];
    assign out_data = w_dout[OUT_W-1:0];
endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain with a behavioural PE and arithmetic reference model.
module tb_mac_result_drain;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [7:0]              len;
    logic                    start_ready;
    logic                    op_en;
    logic                    in_valid;
    logic signed [ACC_W-1:0] acc_in;
    logic signed [ACC_W-1:0] pe_delta;
    logic                    pe_clr;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_sat;

    int             checks = 0;
    int             errors = 0;
    logic [OUT_W:0] exp_q[$];
    int             rdy_mode = 0;
    logic           rdy_force = 1'b1;

    always #5 clk = ~clk;

    mac_result_drain #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .start_ready (start_ready),
        .op_en       (op_en),
        .in_valid    (in_valid),
        .acc_in      (acc_in),
        .pe_clr      (pe_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat)
    );

    // PE: registered accumulator of the product the feeder presents, held at zero by pe_clr
    always @(posedge clk) begin
        if (pe_clr) acc_in <= '0;
        else        acc_in <= acc_in + pe_delta;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [OUT_W:0] model(input longint total);
        logic signed [ACC_W-1:0] wrapped;
        longint s, q, r, lim;
        wrapped = total[ACC_W-1:0];
        s = longint'(wrapped);
        q = longint'(1) << SHIFT;
`ifdef MAC_DRAIN_ROUND_EN
        s = s + q / 2;
`endif
        if (s >= 0) r = s / q;
        else        r = -((-s + q - 1) / q);
        lim = longint'(1) << (OUT_W - 1);
        if (r > lim - 1) return {1'b1, OUT_W'(lim - 1)};
        if (r < -lim)    return {1'b1, OUT_W'(-lim)};
        return {1'b0, OUT_W'(r)};
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    initial begin
        logic           hold;
        logic [OUT_W:0] held;
        logic [OUT_W:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold_stable", {out_sat, out_data}, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%0h required=none", {out_sat, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {out_sat, out_data}, e);
                    end
                end
                hold = out_valid && !out_ready;
                held = {out_sat, out_data};
            end
        end
    end

    // gap_pct < 0 selects the beat pattern in pat (LSB first)
    task automatic run_job(input int n, input int gap_pct, input logic [15:0] pat,
                           input logic use_fixed, input logic signed [31:0] fixed,
                           input int abort_after, input logic chk_lat);
        int waitc, issued, cyc;
        longint total;
        logic beat;
        logic signed [31:0] d;
        waitc = 0;
        while (!start_ready && waitc < 500) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!start_ready) begin
            checks++;
            errors++;
            $display("FAIL start_timeout actual=0 required=1");
            return;
        end
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            exp_q.push_back('0);
            chk("len0_op_en", op_en, 0);
            return;
        end
        issued = 0;
        total  = 0;
        cyc    = 0;
        while (issued < n && cyc < 200) begin
            chk("accum_op_en", op_en, 1);
            chk("accum_pe_clr", pe_clr, 0);
            if (abort_after == issued) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                pe_delta = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_pe_clr", pe_clr, 1);
                chk("abort_op_en", op_en, 0);
                exp_q.delete();
                return;
            end
            if (gap_pct < 0) beat = pat[cyc % 16];
            else             beat = ($urandom_range(0, 99) >= gap_pct);
            if (beat) begin
                d = use_fixed ? fixed : 32'(int'($urandom_range(0, 1048576)) - 524288);
                in_valid = 1'b1;
                pe_delta = d;
                total    = total + longint'(d);
                issued++;
            end else begin
                in_valid = 1'b0;
                pe_delta = '0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        pe_delta = '0;
        if (issued < n) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=%0d required=%0d", issued, n);
            return;
        end
        chk("wait_op_en", op_en, 0);
        chk("wait_pe_clr", pe_clr, 0);
        if (chk_lat) chk("lat_wait_no_valid", out_valid, 0);
        exp_q.push_back(model(total));
        @(posedge clk); #1;
        if (chk_lat) chk("lat_valid", out_valid, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        rdy_mode  = 0;
        rdy_force = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] exp_basic;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; pe_delta = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_pe_clr", pe_clr, 1);
        chk("rst_op_en", op_en, 0);
        rst = 1'b0;
        chk("idle_pe_clr", pe_clr, 1);
        chk("idle_start_ready", start_ready, 1);

        // four beats summing to 0x180, held at the head for inspection
`ifdef MAC_DRAIN_ROUND_EN
        exp_basic = 16'd2;
`else
        exp_basic = 16'd1;
`endif
        rdy_force = 1'b0;
        run_job(4, 0, 16'h0, 1'b1, 32'h60, -1, 1'b1);
        chk("basic_data", out_data, exp_basic);
        chk("basic_sat", out_sat, 0);
        drain();

        rdy_force = 1'b0;
        run_job(1, 0, 16'h0, 1'b1, 32'h7FFFFFFF, -1, 1'b1);
        chk("sat_pos_data", out_data, 16'h7FFF);
        chk("sat_pos_flag", out_sat, 1);
        drain();
        rdy_force = 1'b0;
        run_job(1, 0, 16'h0, 1'b1, 32'h80000000, -1, 1'b1);
        chk("sat_neg_data", out_data, 16'h8000);
        chk("sat_neg_flag", out_sat, 1);
        drain();

        run_job(3, -1, 16'b100101, 1'b0, 32'h0, -1, 1'b1);
        drain();

        rdy_force = 1'b0;
        run_job(0, 0, 16'h0, 1'b0, 32'h0, -1, 1'b0);
        chk("len0_valid", out_valid, 1);
        chk("len0_data", out_data, 0);
        chk("len0_sat", out_sat, 0);
        drain();

        // fill the buffer with the consumer stalled
        rdy_force = 1'b0;
        run_job(2, 20, 16'h0, 1'b0, 32'h0, -1, 1'b0);
        run_job(3, 20, 16'h0, 1'b0, 32'h0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("full_start_ready", start_ready, 0);
            chk("full_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        rdy_force = 1'b1;
        @(posedge clk); #1;
        rdy_force = 1'b0;
        chk("after_pop_start_ready", start_ready, 1);
        exp_q.push_back('0);
        start = 1'b1; len = 8'd0; rdy_force = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rdy_force = 1'b0;
        chk("pushpop_valid", out_valid, 1);
        drain();

        run_job(5, 0, 16'h0, 1'b0, 32'h0, 2, 1'b0);
        rdy_force = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_result", out_valid, 0);

        rdy_mode = 1;
        repeat (30) run_job($urandom_range(0, 8), 30, 16'h0, 1'b0, 32'h0, -1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
